// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
//   wb_state_t : writeback FSM states
//   JUMP_NONE  : jump code for ordinary (non-jump) instructions
//   JUMP_JAL   : jump code for jump-and-link
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b10;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback-stage bus: request inputs from the pipeline, register-file write
// port, forwarding port and status.
//   master : the pipeline / bench driving requests and observing results
//   slave  : the writeback stage
interface wb_stage_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            jump;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [WORD_SIZE-1:0]  pc_in;
    logic [WORD_SIZE-1:0]  alu_in;
    logic [WORD_SIZE-1:0]  mem_in;
    logic [REG_ADDR_W-1:0] rt_num;
    logic [REG_ADDR_W-1:0] rd_num;
    logic                  mem_ready;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [WORD_SIZE-1:0]  rf_wdata;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_num;
    logic [WORD_SIZE-1:0]  fwd_data;
    logic                  busy;

    modport master (
        output in_valid, jump, reg_dst, mem_to_reg, reg_write,
               pc_in, alu_in, mem_in, rt_num, rd_num, mem_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata,
               fwd_valid, fwd_num, fwd_data, busy
    );

    modport slave (
        input  in_valid, jump, reg_dst, mem_to_reg, reg_write,
               pc_in, alu_in, mem_in, rt_num, rd_num, mem_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata,
               fwd_valid, fwd_num, fwd_data, busy
    );

endinterface

// File: rtl/wb_sel.sv
// Combinational destination/data selection for one writeback request.
//   jump_i, reg_dst_i, mem_to_reg_i, reg_write_i : decode controls
//   pc_i, alu_i, mem_i                           : candidate write data
//   rt_num_i, rd_num_i                           : candidate destinations
//   we_c_o   : write wanted (already suppressed for register 0)
//   addr_c_o : destination register
//   data_c_o : write data
//   load_c_o : request is a load that needs mem_i
module wb_sel
    import wb_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned PC_STEP    = 1
) (
    input  logic [1:0]            jump_i,
    input  logic                  reg_dst_i,
    input  logic                  mem_to_reg_i,
    input  logic                  reg_write_i,
    input  logic [WORD_SIZE-1:0]  pc_i,
    input  logic [WORD_SIZE-1:0]  alu_i,
    input  logic [WORD_SIZE-1:0]  mem_i,
    input  logic [REG_ADDR_W-1:0] rt_num_i,
    input  logic [REG_ADDR_W-1:0] rd_num_i,
    output logic                  we_c_o,
    output logic [REG_ADDR_W-1:0] addr_c_o,
    output logic [WORD_SIZE-1:0]  data_c_o,
    output logic                  load_c_o
);

    always_comb begin
        we_c_o   = 1'b0;
        addr_c_o = '0;
        data_c_o = '0;
        load_c_o = 1'b0;
        if (jump_i == JUMP_JAL) begin
            // jal links unconditionally, independent of reg_write
            we_c_o   = 1'b1;
            addr_c_o = REG_ADDR_W'(LINK_REG);
            data_c_o = pc_i + WORD_SIZE'(PC_STEP);
        end else if (jump_i == JUMP_NONE) begin
            we_c_o   = reg_write_i;
            addr_c_o = reg_dst_i ? rd_num_i : rt_num_i;
            data_c_o = mem_to_reg_i ? mem_i : alu_i;
            load_c_o = mem_to_reg_i & reg_write_i;
        end
        // register 0 is hard-wired; never write it
        if (addr_c_o == '0) begin
            we_c_o = 1'b0;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one request per cycle, waits for load data when
// needed, and issues a single-cycle register-file write plus bypass info.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : wb_stage_if.slave (requests in, rf write / forward / status out)
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned PC_STEP    = 1
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);

    wb_state_t             state_q, state_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [WORD_SIZE-1:0]  rf_wdata_q, rf_wdata_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [REG_ADDR_W-1:0] fwd_num_q, fwd_num_d;
    logic [WORD_SIZE-1:0]  fwd_data_q, fwd_data_d;
    logic                  busy_q, busy_d;
    logic                  in_ready_q, in_ready_d;
    logic [REG_ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic                  pend_we_q, pend_we_d;

    logic                  sel_we;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [WORD_SIZE-1:0]  sel_data;
    logic                  sel_load;

    wb_sel #(
        .WORD_SIZE  (WORD_SIZE),
        .REG_ADDR_W (REG_ADDR_W),
        .LINK_REG   (LINK_REG),
        .PC_STEP    (PC_STEP)
    ) u_sel (
        .jump_i       (bus.jump),
        .reg_dst_i    (bus.reg_dst),
        .mem_to_reg_i (bus.mem_to_reg),
        .reg_write_i  (bus.reg_write),
        .pc_i         (bus.pc_in),
        .alu_i        (bus.alu_in),
        .mem_i        (bus.mem_in),
        .rt_num_i     (bus.rt_num),
        .rd_num_i     (bus.rd_num),
        .we_c_o       (sel_we),
        .addr_c_o     (sel_addr),
        .data_c_o     (sel_data),
        .load_c_o     (sel_load)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_num_q   <= '0;
            fwd_data_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            pend_addr_q <= '0;
            pend_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_num_q   <= fwd_num_d;
            fwd_data_q  <= fwd_data_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            pend_addr_q <= pend_addr_d;
            pend_we_q   <= pend_we_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        fwd_valid_d = 1'b0;
        fwd_num_d   = fwd_num_q;
        fwd_data_d  = fwd_data_q;
        pend_addr_d = pend_addr_q;
        pend_we_d   = pend_we_q;

        unique case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (bus.in_valid) begin
                    if (sel_load && !bus.mem_ready) begin
                        // data not back yet: hold the destination for stall detection
                        state_d     = WAIT_MEM;
                        pend_addr_d = sel_addr;
                        pend_we_d   = sel_we;
                        fwd_valid_d = sel_we;
                        fwd_num_d   = sel_addr;
                        fwd_data_d  = '0;
                    end else begin
                        state_d = WRITE;
                        if (sel_we) begin
                            rf_we_d     = 1'b1;
                            rf_waddr_d  = sel_addr;
                            rf_wdata_d  = sel_data;
                            fwd_valid_d = 1'b1;
                            fwd_num_d   = sel_addr;
                            fwd_data_d  = sel_data;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                fwd_valid_d = pend_we_q;
                if (bus.mem_ready) begin
                    state_d = WRITE;
                    if (pend_we_q) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = pend_addr_q;
                        rf_wdata_d = bus.mem_in;
                        fwd_num_d  = pend_addr_q;
                        fwd_data_d = bus.mem_in;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == WAIT_MEM);
        in_ready_d = (state_d != WAIT_MEM);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.fwd_valid = fwd_valid_q;
    assign bus.fwd_num   = fwd_num_q;
    assign bus.fwd_data  = fwd_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width in bits.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-number width.
REQ-003 SHALL have parameter LINK_REG, default 31, destination register for jal.
REQ-004 SHALL have parameter PC_STEP, default 1, link offset added to pc_in (word-addressed PC).
REQ-005 SHALL have clk input, 1 bit: single clock; all state updates on rising edge.
REQ-006 SHALL have rst input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have in_valid input, 1 bit: writeback request present.
REQ-008 SHALL have in_ready output, 1 bit: request accepted when in_valid & in_ready.
REQ-009 SHALL have jump input, 2 bits: 00 none, 10 jal, 01/11 jump without link.
REQ-010 SHALL have reg_dst, mem_to_reg and reg_write inputs, 1 bit each: decode controls.
REQ-011 SHALL have pc_in, alu_in and mem_in inputs, WORD_SIZE each: source values.
REQ-012 SHALL have rt_num and rd_num inputs, REG_ADDR_W each: candidate destinations.
REQ-013 SHALL have mem_ready input, 1 bit: mem_in valid this cycle.
REQ-014 SHALL have rf_we (1), rf_waddr (REG_ADDR_W) and rf_wdata (WORD_SIZE) outputs: register-file write port.
REQ-015 SHALL have fwd_valid (1), fwd_num (REG_ADDR_W) and fwd_data (WORD_SIZE) outputs: bypass of the pending or current write.
REQ-016 SHALL have busy output, 1 bit: high in WAIT_MEM.

Function
REQ-017 SHALL select jal when jump==10: addr LINK_REG, data pc_in+PC_STEP (mod 2^WORD_SIZE); jal writes even if reg_write=0.
REQ-018 SHALL, when jump==00, select addr = reg_dst ? rd_num : rt_num and data = mem_to_reg ? mem_in : alu_in.
REQ-019 SHALL treat jump==01/11 with no link as no-write: accepted, rf_we stays 0.
REQ-020 SHALL suppress every write to register 0 (rf_we=0); address 0 never appears with rf_we=1.
REQ-021 SHALL implement states IDLE, WAIT_MEM and WRITE.
REQ-022 SHALL, on a non-load or no-write accept, go to WRITE next cycle and pulse rf_we for exactly one cycle (latency 1).
REQ-023 SHALL, on a load accept (jump==00, mem_to_reg=1, reg_write=1) with mem_ready=1, capture mem_in and go to WRITE (latency 1).
REQ-024 SHALL, on a load accept with mem_ready=0, latch addr and go to WAIT_MEM; on the first cycle with mem_ready=1, capture mem_in and go to WRITE.
REQ-025 SHALL drive in_ready = (state != WAIT_MEM); accepting in WRITE gives back-to-back throughput of one request per cycle.
REQ-026 SHALL go from WRITE to IDLE when nothing is accepted.
REQ-027 SHALL ignore mem_ready outside the load-accept cycle and WAIT_MEM.
REQ-028 SHALL drive fwd_valid=1 in WAIT_MEM with latched fwd_num and fwd_data=0, for stall detection only.
REQ-029 SHALL drive fwd_valid=1 in WRITE with fwd_num/fwd_data equal to rf_waddr/rf_wdata.
REQ-030 SHALL force fwd_valid=0 whenever the write is suppressed.
REQ-031 SHALL keep rf_waddr/rf_wdata registered, holding the last value while rf_we=0.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, enter IDLE and set rf_we, fwd_valid and busy to 0; rf_waddr, fwd_num, rf_wdata and fwd_data to 0; in_ready to 1 from the next cycle.
REQ-033 SHALL, when rst hits WAIT_MEM or WRITE, drop the pending write with no rf_we pulse; rst overrides in_valid and mem_ready.

Structure
REQ-034 SHALL place wb_state_t (IDLE, WAIT_MEM, WRITE) and constants JUMP_NONE=2'b00 and JUMP_JAL=2'b10 in shared package wb_pkg.
REQ-035 SHALL put destination/data selection (REQ-017..020) in one combinational sub-module wb_sel, instanced once.

Verification
REQ-036 SHALL check jal: jump=10, pc_in=0x100 -> next cycle rf_we=1, rf_waddr=31, rf_wdata=0x101.
REQ-037 SHALL check R-type: reg_dst=1, rd_num=8, alu_in=0xDEAD, reg_write=1 -> rf_waddr=8, rf_wdata=0xDEAD one cycle later, single pulse.
REQ-038 SHALL check stalled load: rt_num=4, mem_ready low 3 cycles, then mem_in=0x55 -> busy and in_ready=0 for 3 cycles, then rf_we with 4/0x55.
REQ-039 SHALL check $zero: rd_num=0, reg_write=1 -> rf_we=0 and fwd_valid=0.
REQ-040 SHALL check back-to-back: three R-type requests on consecutive cycles -> three consecutive rf_we pulses in order.
REQ-041 SHALL check reset: rst asserted in WAIT_MEM -> no rf_we; next cycle in_ready=1 and busy=0.
